// File: rtl/reg_bank_ms_if.sv
// Bus bundle for reg_bank_ms: write-side controls, read address and the observed outputs.
// The master drives the switches/keys side; the slave is the register bank.
interface reg_bank_ms_if #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned ADDR_W = 2
);
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        mode;
    logic [WIDTH-1:0]  d;
    logic              ser_in;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  q;
    logic              zero;
    logic              ser_out;
    logic              carry;
    logic              upd;

    modport master (
        output en, addr, mode, d, ser_in, rd_addr,
        input  q, zero, ser_out, carry, upd
    );

    modport slave (
        input  en, addr, mode, d, ser_in, rd_addr,
        output q, zero, ser_out, carry, upd
    );
endinterface

// File: rtl/reg_bank_ms.sv
// Multi-mode register bank: DEPTH words of WIDTH bits, per-clock load/shift/rotate/inc/clear
// on one addressed word, with an independent combinational read port.
module reg_bank_ms #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic                clock,
    input  logic                resetn,
    reg_bank_ms_if.slave        bus
);
    localparam int unsigned M = WIDTH - 1;

    typedef enum logic [2:0] {
        ModeHold = 3'b000,
        ModeLoad = 3'b001,
        ModeShl  = 3'b010,
        ModeShr  = 3'b011,
        ModeRol  = 3'b100,
        ModeRor  = 3'b101,
        ModeInc  = 3'b110,
        ModeClr  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             ser_out_q, ser_out_d;
    logic             carry_q, carry_d;
    logic             upd_q, upd_d;
    logic             accept;
    logic [WIDTH-1:0] w;
    logic             rd_valid;

    // Addresses past DEPTH exist only when DEPTH is not a power of two; such writes are dropped.
    assign accept = bus.en && (32'(bus.addr) < DEPTH);

    always_comb begin
        mem_d     = mem_q;
        ser_out_d = ser_out_q;
        carry_d   = carry_q;
        upd_d     = accept;
        w         = '0;
        if (accept) begin
            w = mem_q[bus.addr];
            unique case (mode_e'(bus.mode))
                ModeHold: mem_d[bus.addr] = w;
                ModeLoad: mem_d[bus.addr] = bus.d;
                ModeShl: begin
                    mem_d[bus.addr] = {w[M-1:0], bus.ser_in};
                    ser_out_d       = w[M];
                end
                ModeShr: begin
                    mem_d[bus.addr] = {bus.ser_in, w[M:1]};
                    ser_out_d       = w[0];
                end
                ModeRol: begin
                    mem_d[bus.addr] = {w[M-1:0], w[M]};
                    ser_out_d       = w[M];
                end
                ModeRor: begin
                    mem_d[bus.addr] = {w[0], w[M:1]};
                    ser_out_d       = w[0];
                end
                ModeInc: begin
                    mem_d[bus.addr] = w + {{(WIDTH-1){1'b0}}, 1'b1};
                    carry_d         = &w;
                end
                ModeClr: mem_d[bus.addr] = '0;
                default: mem_d[bus.addr] = w;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            ser_out_q <= 1'b0;
            carry_q   <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            ser_out_q <= ser_out_d;
            carry_q   <= carry_d;
            upd_q     <= upd_d;
        end
    end

    // Read port has no write bypass: it sees only the registered words.
    assign rd_valid    = 32'(bus.rd_addr) < DEPTH;
    assign bus.q       = rd_valid ? mem_q[bus.rd_addr] : '0;
    assign bus.zero    = (bus.q == '0);
    assign bus.ser_out = ser_out_q;
    assign bus.carry   = carry_q;
    assign bus.upd     = upd_q;
endmodule

// File: tb/tb_reg_bank_ms.sv
// Directed bench for reg_bank_ms (WIDTH=3, DEPTH=3, ADDR_W=2): vector table plus
// hand sequences for asynchronous reset, reset priority and read-during-write.
module tb_reg_bank_ms;
    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] ROL  = 3'b100;
    localparam logic [2:0] ROR  = 3'b101;
    localparam logic [2:0] INC  = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

    typedef struct {
        logic       en;
        logic [1:0] addr;
        logic [2:0] mode;
        logic [2:0] d;
        logic       ser_in;
        logic [1:0] rd_addr;
        logic [2:0] q;
        logic       zero;
        logic       ser_out;
        logic       carry;
        logic       upd;
    } vec_t;

    logic clock;
    logic resetn;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    reg_bank_ms_if #(.WIDTH(3), .ADDR_W(2)) bus ();

    reg_bank_ms #(
        .WIDTH (3),
        .DEPTH (3),
        .ADDR_W(2)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic en, input logic [1:0] addr, input logic [2:0] mode,
                                input logic [2:0] d, input logic si, input logic [1:0] rd,
                                input logic [2:0] q, input logic z, input logic so,
                                input logic c, input logic u);
        vec_t v;
        v.en = en; v.addr = addr; v.mode = mode; v.d = d; v.ser_in = si; v.rd_addr = rd;
        v.q = q; v.zero = z; v.ser_out = so; v.carry = c; v.upd = u;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic en, input logic [1:0] addr, input logic [2:0] mode,
                         input logic [2:0] d, input logic si, input logic [1:0] rd);
        bus.en = en; bus.addr = addr; bus.mode = mode; bus.d = d; bus.ser_in = si;
        bus.rd_addr = rd;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //  en addr mode  d  si rd   q  z so  c  u
        add(1, 2, LOAD, 5, 0, 2,   5, 0, 0, 0, 1);
        add(0, 2, LOAD, 7, 0, 2,   5, 0, 0, 0, 0);
        add(0, 0, HOLD, 0, 0, 0,   0, 1, 0, 0, 0);
        add(0, 0, HOLD, 0, 0, 1,   0, 1, 0, 0, 0);
        add(1, 1, LOAD, 4, 0, 1,   4, 0, 0, 0, 1);
        add(1, 1, SHL,  0, 1, 1,   1, 0, 1, 0, 1);
        add(1, 1, ROR,  0, 0, 1,   4, 0, 1, 0, 1);
        add(1, 1, SHR,  0, 0, 1,   2, 0, 0, 0, 1);
        add(1, 0, LOAD, 6, 0, 0,   6, 0, 0, 0, 1);
        add(1, 0, INC,  0, 0, 0,   7, 0, 0, 0, 1);
        add(1, 0, INC,  0, 0, 0,   0, 1, 0, 1, 1);
        add(1, 0, LOAD, 3, 0, 0,   3, 0, 0, 1, 1);
        add(1, 1, ROL,  0, 0, 1,   4, 0, 0, 1, 1);
        add(1, 1, ROL,  0, 0, 1,   1, 0, 1, 1, 1);
        add(0, 1, CLR,  0, 0, 1,   1, 0, 1, 1, 0);
        add(1, 3, LOAD, 7, 0, 3,   0, 1, 1, 1, 0);
        add(1, 3, SHL,  0, 0, 3,   0, 1, 1, 1, 0);
        add(1, 2, HOLD, 0, 0, 2,   5, 0, 1, 1, 1);
        add(1, 2, CLR,  0, 0, 2,   0, 1, 1, 1, 1);
        add(1, 1, INC,  0, 0, 1,   2, 0, 1, 0, 1);
        add(1, 1, SHR,  0, 1, 1,   5, 0, 0, 0, 1);
        add(1, 0, LOAD, 7, 0, 0,   7, 0, 0, 0, 1);
        add(1, 0, INC,  0, 0, 0,   0, 1, 0, 1, 1);
        add(1, 1, SHL,  0, 0, 1,   2, 0, 1, 1, 1);

        resetn = 1'b0;
        drive(0, 0, HOLD, 0, 0, 0);
        tick();
        tick();
        chk("rst_q", 32'(bus.q), 0);
        chk("rst_zero", 32'(bus.zero), 1);
        chk("rst_ser_out", 32'(bus.ser_out), 0);
        chk("rst_carry", 32'(bus.carry), 0);
        chk("rst_upd", 32'(bus.upd), 0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].addr, vecs[i].mode, vecs[i].d, vecs[i].ser_in,
                  vecs[i].rd_addr);
            tick();
            chk($sformatf("v%0d_q", i), 32'(bus.q), 32'(vecs[i].q));
            chk($sformatf("v%0d_zero", i), 32'(bus.zero), 32'(vecs[i].zero));
            chk($sformatf("v%0d_ser_out", i), 32'(bus.ser_out), 32'(vecs[i].ser_out));
            chk($sformatf("v%0d_carry", i), 32'(bus.carry), 32'(vecs[i].carry));
            chk($sformatf("v%0d_upd", i), 32'(bus.upd), 32'(vecs[i].upd));
        end

        // Asynchronous reset between edges: word1=2, SerOut=1, Carry=1, Upd=1 beforehand.
        drive(0, 0, HOLD, 0, 0, 1);
        resetn = 1'b0;
        #1;
        chk("async_q", 32'(bus.q), 0);
        chk("async_zero", 32'(bus.zero), 1);
        chk("async_ser_out", 32'(bus.ser_out), 0);
        chk("async_carry", 32'(bus.carry), 0);
        chk("async_upd", 32'(bus.upd), 0);

        // Reset held across an edge carrying a load: word must stay cleared.
        drive(1, 0, LOAD, 7, 0, 0);
        tick();
        chk("prio_q", 32'(bus.q), 0);
        chk("prio_upd", 32'(bus.upd), 0);
        resetn = 1'b1;
        tick();
        chk("release_q", 32'(bus.q), 7);
        chk("release_upd", 32'(bus.upd), 1);

        // Same-address read during write: old value until the edge, D never leaks to Q.
        drive(1, 0, LOAD, 2, 0, 0);
        #1;
        chk("nobypass_q", 32'(bus.q), 7);
        tick();
        chk("after_wr_q", 32'(bus.q), 2);
        drive(0, 0, LOAD, 5, 0, 0);
        tick();
        chk("idle_upd", 32'(bus.upd), 0);
        chk("idle_q", 32'(bus.q), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
